// File: rtl/maestro_hci_core_width_serializer.sv
// Width serializer for the HCI core port: wide pass-through, or split each DW
// request into DW_SUB beats on the lower lanes and reassemble the read data.
module maestro_hci_core_width_serializer #(
  parameter int unsigned DW     = 128,
  parameter int unsigned DW_SUB = 32,
  parameter int unsigned AW     = 32,
  parameter int unsigned BW     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             sel_i,
  input  logic             in_req,
  input  logic             in_wen,
  input  logic [AW-1:0]    in_add,
  input  logic [DW/BW-1:0] in_be,
  input  logic [DW-1:0]    in_data,
  output logic             in_gnt,
  output logic             in_r_valid,
  output logic [DW-1:0]    in_r_data,
  output logic             out_req,
  output logic             out_wen,
  output logic [AW-1:0]    out_add,
  output logic [DW/BW-1:0] out_be,
  output logic [DW-1:0]    out_data,
  input  logic             out_gnt,
  input  logic             out_r_valid,
  input  logic [DW-1:0]    out_r_data
);

  localparam int unsigned NB_BEATS = DW / DW_SUB;
  localparam int unsigned BEAT_W   = $clog2(NB_BEATS);
  localparam int unsigned BE_SUB   = DW_SUB / BW;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB_BEATS - 1);

  logic [BEAT_W-1:0]              beat_q;
  logic                           mode_q;
  logic                           gnt_q;
  logic                           last_q;
  logic [(NB_BEATS-1)*DW_SUB-1:0] rbuf_q;

  logic        mode_wide;
  logic        beat_last;
  logic        beat_fire;
  logic [31:0] beat_ext;
  logic [31:0] rd_idx;

  // sel_i is only honoured between bursts; mid-burst the latched mode wins
  assign mode_wide = (beat_q == '0) ? sel_i : mode_q;
  assign beat_last = (beat_q == LAST_BEAT);
  assign beat_fire = out_req & out_gnt;
  assign beat_ext  = 32'(beat_q);
  assign rd_idx    = (beat_ext == 32'd0) ? 32'd0 : beat_ext - 32'd1;

  always_comb begin
    out_req  = in_req;
    out_wen  = in_wen;
    out_add  = in_add;
    out_be   = in_be;
    out_data = in_data;
    in_gnt   = out_gnt;
    if (!mode_wide) begin
      out_add                = in_add + AW'(beat_ext * BE_SUB);
      out_be                 = '0;
      out_be[BE_SUB-1:0]     = in_be[beat_ext*BE_SUB +: BE_SUB];
      out_data               = '0;
      out_data[DW_SUB-1:0]   = in_data[beat_ext*DW_SUB +: DW_SUB];
      in_gnt                 = out_gnt & in_req & beat_last;
    end
  end

  // Responses arrive one cycle after the grant, so they follow the mode
  // latched for that grant (mode_q) rather than the live effective mode.
  always_comb begin
    in_r_valid = out_r_valid;
    in_r_data  = out_r_data;
    if (!mode_q) begin
      in_r_valid = out_r_valid & gnt_q & last_q;
      in_r_data  = in_r_valid ? {out_r_data[DW_SUB-1:0], rbuf_q} : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
      mode_q <= 1'b1;
      gnt_q  <= 1'b0;
      last_q <= 1'b0;
      rbuf_q <= '0;
    end else if (clear_i) begin
      beat_q <= '0;
      mode_q <= 1'b1;
      gnt_q  <= 1'b0;
      last_q <= 1'b0;
      rbuf_q <= '0;
    end else begin
      if (beat_q == '0) mode_q <= sel_i;
      gnt_q  <= beat_fire;
      last_q <= beat_last;
      if (!mode_wide && beat_fire) beat_q <= beat_q + BEAT_W'(1);
      if (!mode_q && out_r_valid && gnt_q && !last_q && in_wen)
        rbuf_q[rd_idx*DW_SUB +: DW_SUB] <= out_r_data[DW_SUB-1:0];
    end
  end

endmodule

// File: tb/tb_maestro_hci_core_width_serializer.sv
// Scoreboard bench: stimulus pushes expected downstream beats and upstream
// responses; a negedge monitor pops and compares them.
module tb_maestro_hci_core_width_serializer;

  localparam int NB = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          sel_i = 1'b1;
  logic          in_req = 1'b0;
  logic          in_wen = 1'b0;
  logic [31:0]   in_add = '0;
  logic [15:0]   in_be = '0;
  logic [127:0]  in_data = '0;
  logic          in_gnt, in_r_valid;
  logic [127:0]  in_r_data;
  logic          out_req, out_wen;
  logic [31:0]   out_add;
  logic [15:0]   out_be;
  logic [127:0]  out_data;
  logic          out_gnt = 1'b0;
  logic          out_r_valid;
  logic [127:0]  out_r_data;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0]  add;
    logic [15:0]  be;
    logic [127:0] data;
    logic         wen;
    logic         last;
  } beat_t;

  beat_t        exp_beats[$];
  logic [128:0] exp_resp[$];
  beat_t        mb;
  logic [128:0] mr;

  maestro_hci_core_width_serializer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .sel_i(sel_i),
    .in_req(in_req), .in_wen(in_wen), .in_add(in_add), .in_be(in_be),
    .in_data(in_data), .in_gnt(in_gnt), .in_r_valid(in_r_valid),
    .in_r_data(in_r_data), .out_req(out_req), .out_wen(out_wen),
    .out_add(out_add), .out_be(out_be), .out_data(out_data),
    .out_gnt(out_gnt), .out_r_valid(out_r_valid), .out_r_data(out_r_data)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] mf(input logic [31:0] a);
    return {~a, a ^ 32'h5A5A5A5A, a + 32'h1000, a};
  endfunction

  // downstream memory: r_valid one cycle after every grant
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_r_valid <= 1'b0;
      out_r_data  <= '0;
    end else begin
      out_r_valid <= out_req & out_gnt;
      out_r_data  <= (out_req & out_gnt) ? mf(out_add) : '0;
    end
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (out_req && out_gnt) begin
        total++;
        if (exp_beats.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected add=%h", out_add);
        end else begin
          mb = exp_beats.pop_front();
          if (out_add !== mb.add || out_be !== mb.be || out_data !== mb.data ||
              out_wen !== mb.wen || in_gnt !== mb.last) begin
            bad++;
            $display("FAIL beat got add=%h be=%h data=%h wen=%b gnt=%b want add=%h be=%h data=%h wen=%b gnt=%b",
                     out_add, out_be, out_data, out_wen, in_gnt,
                     mb.add, mb.be, mb.data, mb.wen, mb.last);
          end
        end
      end else if (!out_gnt) begin
        total++;
        if (in_gnt !== 1'b0) begin
          bad++;
          $display("FAIL gnt_without_out_gnt got=%b want=0", in_gnt);
        end
      end
      if (in_r_valid) begin
        total++;
        if (exp_resp.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected data=%h", in_r_data);
        end else begin
          mr = exp_resp.pop_front();
          if (mr[128] && in_r_data !== mr[127:0]) begin
            bad++;
            $display("FAIL resp_data got=%h want=%h", in_r_data, mr[127:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic do_txn(input logic sel, input logic wen, input logic [31:0] add,
                        input logic [15:0] be, input logic [127:0] data,
                        input bit rnd, input logic [15:0] stall, input int toggle,
                        input int abort, output int gcyc);
    int cyc;
    int grants;
    logic [127:0] rd;
    beat_t b;
    @(posedge clk_i); #1;
    sel_i = sel; in_req = 1'b1; in_wen = wen; in_add = add; in_be = be; in_data = data;
    if (sel) begin
      b = '{add: add, be: be, data: data, wen: wen, last: 1'b1};
      exp_beats.push_back(b);
      rd = mf(add);
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (abort == 0 || k < abort) begin
          b.add  = add + 32'(4 * k);
          b.be   = {12'h0, be[k*4 +: 4]};
          b.data = {96'h0, data[k*32 +: 32]};
          b.wen  = wen;
          b.last = (k == NB - 1);
          exp_beats.push_back(b);
        end
        rd[k*32 +: 32] = mf(add + 32'(4 * k))[31:0];
      end
    end
    if (abort == 0) exp_resp.push_back({wen, rd});
    cyc = 0; grants = 0; gcyc = -1;
    while (1) begin
      out_gnt = rnd ? ($urandom_range(0, 3) != 0) : !stall[cyc % 16];
      @(negedge clk_i);
      if (out_req && out_gnt) grants++;
      if (in_gnt) begin gcyc = cyc; break; end
      if (abort != 0 && grants == abort) break;
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL txn_timeout add=%h got=no_gnt want=gnt", add);
        break;
      end
      @(posedge clk_i); #1;
      cyc++;
      if (toggle > 0 && grants == toggle) sel_i = 1'b1;
    end
    if (abort != 0) begin
      @(posedge clk_i); #1;
      in_req = 1'b0; clear_i = 1'b1;
      @(negedge clk_i);
      chk("clear_gnt", {127'h0, in_gnt}, 128'h0);
      chk("clear_rvalid", {127'h0, in_r_valid}, 128'h0);
      @(posedge clk_i); #1;
      clear_i = 1'b0;
    end
  endtask

  task automatic finish_check(input string name);
    @(posedge clk_i); #1;
    in_req = 1'b0;
    @(negedge clk_i);
    chk(name, {127'h0, in_r_valid}, 128'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc;
    logic [31:0] a;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_gnt", {127'h0, in_gnt}, 128'h0);
    chk("rst_in_r_valid", {127'h0, in_r_valid}, 128'h0);
    chk("rst_in_r_data", in_r_data, 128'h0);
    chk("rst_out_req", {127'h0, out_req}, 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    #1 rst_ni = 1'b1;

    do_txn(1'b1, 1'b1, 32'h100, 16'hFFFF, '0, 0, 16'h0, 0, 0, gc);
    chk("wide_gnt_cycle", 128'(gc), 128'd0);
    finish_check("wide_rvalid");

    do_txn(1'b0, 1'b1, 32'h100, 16'hFFFF, '0, 0, 16'h0, 0, 0, gc);
    chk("narrow_gnt_cycle", 128'(gc), 128'd3);
    finish_check("narrow_rvalid");

    do_txn(1'b0, 1'b0, 32'h180, 16'h0F0F, {4{$urandom}}, 0, 16'b0110, 0, 0, gc);
    chk("stall_gnt_cycle", 128'(gc), 128'd5);
    finish_check("stall_rvalid");

    do_txn(1'b0, 1'b1, 32'h200, 16'hFFFF, '0, 0, 16'h0, 2, 0, gc);
    chk("modechg_narrow_gnt", 128'(gc), 128'd3);
    do_txn(1'b1, 1'b0, 32'h300, 16'h1234, {4{$urandom}}, 0, 16'h0, 0, 0, gc);
    chk("modechg_wide_gnt", 128'(gc), 128'd0);
    finish_check("modechg_rvalid");

    do_txn(1'b0, 1'b1, 32'hFFFFFFF8, 16'hFFFF, '0, 0, 16'h0, 0, 0, gc);
    chk("wrap_gnt_cycle", 128'(gc), 128'd3);
    finish_check("wrap_rvalid");

    do_txn(1'b0, 1'b1, 32'h400, 16'hFFFF, '0, 0, 16'h0, 0, 3, gc);
    do_txn(1'b0, 1'b1, 32'h400, 16'hFFFF, '0, 0, 16'h0, 0, 0, gc);
    chk("after_clear_gnt", 128'(gc), 128'd3);
    finish_check("after_clear_rvalid");

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 1, 16'h0, 0, 0, gc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1;
        in_req = 1'b0;
      end
    end
    @(posedge clk_i); #1;
    in_req = 1'b0;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    chk("beats_drained", 128'(exp_beats.size()), 128'd0);
    chk("resps_drained", 128'(exp_resp.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maestro_hci_core_width_serializer.md
# maestro_hci_core_width_serializer

Sits directly upstream of the HWPE interconnect, on the accelerator's wide HCI core port. In wide mode (`sel_i=1`) it forwards the full-width `DW` request unchanged. In narrow mode (`sel_i=0`) it splits each `DW` transaction into `NB_BEATS = DW/DW_SUB` consecutive `DW_SUB` beats on the lower lanes. It also reassembles the read data, so the accelerator sees one `DW`-wide transaction in both modes.

## Interface
- `DW`, 128: upstream/downstream data width (bits).
- `DW_SUB`, 32: narrow-mode beat width.
  - `DW % DW_SUB == 0`.
  - `NB_BEATS` is a power of two ≥ 2.
- `AW`, 32: byte address width.
- `BW`, 8: bits per byte-enable.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous clear; same effect as reset.
- `sel_i`  in  1  1 = wide mode, 0 = narrow (serialized) mode.
- `in_req`, `in_wen`, `in_add[AW]`, `in_be[DW/BW]`, `in_data[DW]`  in: upstream request. `wen=1` is a read.
- `in_gnt`, `in_r_valid`  out  1: upstream handshake.
- `in_r_data`  out  `DW`: upstream read data.
- `out_req`, `out_wen`  out  1: downstream request.
- `out_add`  out  `AW`: downstream byte address.
- `out_be`  out  `DW/BW`: downstream byte enables.
- `out_data`  out  `DW`: downstream write data.
- `out_gnt`, `out_r_valid`  in  1: downstream handshake.
- `out_r_data`  in  `DW`: downstream read data.

## Operation
- **Protocol (both sides).**
  - `req`, `add`, `wen`, `be` and `data` are held stable until `gnt`.
  - `r_valid` comes exactly one cycle after `gnt`, for reads and writes alike.
- **State registers.**
  - `beat_q` (log2 `NB_BEATS` bits).
  - `mode_q`.
  - `gnt_q`.
  - `last_q`.
  - `rbuf_q[(NB_BEATS-1)*DW_SUB]`.
- **Mode latch.**
  - Effective mode = `sel_i` when `beat_q==0`; `mode_q` otherwise.
  - `mode_q` loads the effective mode on every cycle with `beat_q==0`.
  - So `sel_i` changes in mid-burst are ignored until the burst completes.
- **Wide mode.**
  - Pure pass-through: `out_*=in_*`, `in_gnt=out_gnt`, `in_r_valid=out_r_valid`, `in_r_data=out_r_data`.
  - `beat_q` stays 0.
- **Narrow mode, request side.**
  - `out_req=in_req`; `out_wen=in_wen`.
  - `out_add = in_add + beat_q*(DW_SUB/BW)`, modulo 2^AW (wrap-around allowed).
  - `out_be[DW_SUB/BW-1:0]` = slice `beat_q` of `in_be`; upper bits 0.
  - `out_data[DW_SUB-1:0]` = slice `beat_q` of `in_data`; upper bits 0.
  - Each cycle with `out_req & out_gnt`, `beat_q` increments and wraps from `NB_BEATS-1` to 0.
  - `in_gnt = out_gnt & in_req & (beat_q==NB_BEATS-1)`. Earlier beats are never granted upstream.
- **Narrow mode, response side.**
  - `gnt_q <= out_req & out_gnt`.
  - `last_q <= (beat_q==NB_BEATS-1)`.
  - When `out_r_valid & gnt_q & !last_q & in_wen`, capture `out_r_data[DW_SUB-1:0]` into `rbuf_q` slice `beat_q-1`.
  - `in_r_valid = out_r_valid & gnt_q & last_q`.
  - `in_r_data` = {`out_r_data[DW_SUB-1:0]`, `rbuf_q`}: top slice is the live last beat, lower slices come from the buffer.
  - `in_r_data` is 0 when `in_r_valid=0`.
- **Dropped request.** If `in_req` drops mid-burst (a protocol violation), `beat_q` holds. There is no abort.

## Timing
- Reset/clear values:
  - `beat_q=0`, `mode_q=1`, `gnt_q=0`, `last_q=0`, `rbuf_q=0`.
  - `in_gnt=0`, `in_r_valid=0`, `in_r_data=0`.
  - `out_*` follow the combinational equations, so all are 0 while `in_req=0`.
- Wide mode: zero added latency, fully combinational.
- Narrow mode, with `out_gnt` tied high:
  - Beats are issued in cycles 0..`NB_BEATS-1`.
  - `in_gnt` is asserted in cycle `NB_BEATS-1`.
  - `in_r_valid` is asserted in cycle `NB_BEATS`.
  - Upstream throughput is one transaction per `NB_BEATS` cycles.
- Stall: `out_gnt=0` holds `beat_q` and all outputs. Stalls may occur on any beat.
- Back-to-back transactions: a new transaction's beat 0 may issue in the cycle after the previous last beat. This overlaps with the previous `in_r_valid` cycle.
- Reset or `clear_i` mid-burst: the burst is dropped immediately and the next request starts at beat 0.

## Test plan
- **Wide read:** `sel_i=1`, `add=0x100`, `out_r_data=0xDEAD..BEEF`, `out_gnt=1` -> `in_gnt` in the same cycle; next cycle `in_r_valid=1` with identical data; `beat_q` stays 0.
- **Narrow read:** `sel_i=0`, DW=128/DW_SUB=32, `add=0x100`, memory returns `add` as data -> `out_add`=0x100, 0x104, 0x108, 0x10C in cycles 0-3; `in_gnt` in cycle 3 only; cycle 4 `in_r_data`=`{0x10C,0x108,0x104,0x100}`.
- **Narrow write with stalls:** `be=0x0F0F`, `out_gnt` low in cycles 1 and 2 -> `out_be`=0xF, 0x0, 0xF, 0x0 per beat; `in_gnt` in cycle 5; `in_r_valid` in cycle 6.
- **Mode change mid-burst:** `sel_i` toggles to 1 after beat 1 -> beats 2 and 3 are still narrow; the following transaction is wide.
- **Address wrap:** `add=0xFFFFFFF8` with AW=32 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- **Clear mid-burst:** `clear_i` pulsed after beat 2 -> `beat_q=0`; no `in_gnt`/`in_r_valid` for the aborted burst; the next request restarts at `in_add`.
